// File: rtl/alu_response_checker.sv
// Response checker for the 32-bit ALU. It recomputes the expected result, overflow and
// zero flag for each accepted vector and compares them with the ALU's outputs. It keeps
// saturating pass/fail counts, a sticky error flag and a capture of the first failure.
// Pipeline: stage 1 registers the vector, stage 2 scores it one edge later.
module alu_response_checker #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_m,
  input  logic             i_s1,
  input  logic             i_s0,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_add_sub_overflow,
  input  logic             i_iszero,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [CNT_W-1:0] o_pass_count,
  output logic [CNT_W-1:0] o_fail_count,
  output logic [CNT_W-1:0] o_first_fail_idx,
  output logic [WIDTH-1:0] o_first_fail_expected,
  output logic [WIDTH-1:0] o_first_fail_actual
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [CNT_W-1:0] r_pass_count;
  logic [CNT_W-1:0] r_fail_count;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_first_idx;
  logic [WIDTH-1:0] r_first_exp;
  logic [WIDTH-1:0] r_first_act;

  // Stage-1 registered copy of the vector and the ALU response
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             r_iszero;
  logic [CNT_W-1:0] r_s1_idx;

  logic             w_accept;
  logic             w_start_ok;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_exp_result;
  logic             w_exp_ovf;
  logic             w_exp_zero;
  logic             w_arith;
  logic             w_mismatch;

  assign w_accept   = (r_state == StRun) && i_in_valid;
  assign w_start_ok = i_start && ((r_state == StIdle) || (r_state == StDone));

  // Stage 1: capture accepted vectors; a new session flushes the pipeline
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
      r_iszero   <= 1'b0;
      r_s1_idx   <= '0;
    end else begin
      r_s1_valid <= w_accept && !w_start_ok;
      if (w_accept) begin
        r_a      <= i_a;
        r_b      <= i_b;
        r_op     <= {i_m, i_s1, i_s0};
        r_result <= i_result;
        r_ovf    <= i_add_sub_overflow;
        r_iszero <= i_iszero;
        r_s1_idx <= r_idx;
      end
    end
  end

  // Expected ALU behaviour computed from the stage-1 copy
  always_comb begin
    w_sum        = r_a + r_b;
    w_diff       = r_a - r_b;
    w_exp_result = '0;
    unique case (r_op)
      3'b000: w_exp_result = ~r_a;
      3'b001: w_exp_result = r_a & r_b;
      3'b010: w_exp_result = r_a ^ r_b;
      3'b011: w_exp_result = r_a | r_b;
      3'b100: w_exp_result = r_a - 1'b1;
      3'b101: w_exp_result = w_sum;
      3'b110: w_exp_result = w_diff;
      3'b111: w_exp_result = r_a + 1'b1;
      default: w_exp_result = '0;
    endcase
    w_arith    = (r_op == 3'b101) || (r_op == 3'b110);
    w_exp_ovf  = 1'b0;
    if (r_op == 3'b101) begin
      w_exp_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    end else if (r_op == 3'b110) begin
      w_exp_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
    end
    w_exp_zero = (w_exp_result == '0);
    // Overflow only matters for add/sub
    w_mismatch = (r_result != w_exp_result) || (r_iszero != w_exp_zero) ||
                 (w_arith && (r_ovf != w_exp_ovf));
  end

  // Session FSM plus stage-2 scoring; a start clears everything scoring just wrote
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_pass_count <= '0;
      r_fail_count <= '0;
      r_idx        <= '0;
      r_first_idx  <= '0;
      r_first_exp  <= '0;
      r_first_act  <= '0;
    end else begin
      if (r_s1_valid) begin
        if (w_mismatch) begin
          if (!r_error) begin
            r_first_idx <= r_s1_idx;
            r_first_exp <= w_exp_result;
            r_first_act <= r_result;
          end
          r_error <= 1'b1;
          if (r_fail_count != CntMax) r_fail_count <= r_fail_count + 1'b1;
        end else if (r_pass_count != CntMax) begin
          r_pass_count <= r_pass_count + 1'b1;
        end
      end
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_state      <= StRun;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_pass_count <= '0;
            r_fail_count <= '0;
            r_idx        <= '0;
            r_first_idx  <= '0;
            r_first_exp  <= '0;
            r_first_act  <= '0;
          end
        end
        StRun: begin
          if (w_accept && (r_idx != CntMax)) r_idx <= r_idx + 1'b1;
          if (i_stop) r_state <= StDrain;
        end
        StDrain: begin
          // The last accepted vector is scored on this same edge
          r_state <= StDone;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy                = r_busy;
  assign o_done                = r_done;
  assign o_error               = r_error;
  assign o_pass_count          = r_pass_count;
  assign o_fail_count          = r_fail_count;
  assign o_first_fail_idx      = r_first_idx;
  assign o_first_fail_expected = r_first_exp;
  assign o_first_fail_actual   = r_first_act;

endmodule

// File: tb/tb_alu_response_checker.sv
// Directed bench for alu_response_checker; a second instance with 4-bit counters
// shares the stimulus so saturation can be observed.
module tb_alu_response_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic [31:0] result = '0;
  logic        ovf = 1'b0;
  logic        zf = 1'b0;

  logic        busy, done, error;
  logic [15:0] pass_count, fail_count, ff_idx;
  logic [31:0] ff_exp, ff_act;
  logic        s_busy, s_done, s_error;
  logic [3:0]  s_pass, s_fail, s_idx;
  logic [31:0] s_exp, s_act;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_response_checker #(.WIDTH(32), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_in_valid(in_valid),
    .i_a(a), .i_b(b), .i_m(op[2]), .i_s1(op[1]), .i_s0(op[0]), .i_result(result),
    .i_add_sub_overflow(ovf), .i_iszero(zf), .o_busy(busy), .o_done(done), .o_error(error),
    .o_pass_count(pass_count), .o_fail_count(fail_count), .o_first_fail_idx(ff_idx),
    .o_first_fail_expected(ff_exp), .o_first_fail_actual(ff_act)
  );

  alu_response_checker #(.WIDTH(32), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_in_valid(in_valid),
    .i_a(a), .i_b(b), .i_m(op[2]), .i_s1(op[1]), .i_s0(op[0]), .i_result(result),
    .i_add_sub_overflow(ovf), .i_iszero(zf), .o_busy(s_busy), .o_done(s_done),
    .o_error(s_error), .o_pass_count(s_pass), .o_fail_count(s_fail), .o_first_fail_idx(s_idx),
    .o_first_fail_expected(s_exp), .o_first_fail_actual(s_act)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] vop,
                      input logic [31:0] vres, input logic vovf, input logic vz);
    in_valid = 1'b1; a = va; b = vb; op = vop; result = vres; ovf = vovf; zf = vz;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_pass", 32'(pass_count), 32'd0);
    rst = 1'b0;
    tick();

    // Logic ops with a correct ALU
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    send(32'd5, 32'd3, 3'b001, 32'd1, 1'b0, 1'b0);
    send(32'd5, 32'd3, 3'b010, 32'd6, 1'b0, 1'b0);
    send(32'd5, 32'd3, 3'b011, 32'd7, 1'b0, 1'b0);
    send(32'd5, 32'd0, 3'b000, 32'hFFFF_FFFA, 1'b0, 1'b0);
    pulse_stop();
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_done", 32'(done), 32'd0);
    tick();
    chk("logic_done", 32'(done), 32'd1);
    chk("logic_busy", 32'(busy), 32'd0);
    chk("logic_pass", 32'(pass_count), 32'd4);
    chk("logic_fail", 32'(fail_count), 32'd0);
    chk("logic_error", 32'(error), 32'd0);

    // Arithmetic and overflow; last vector arrives with stop
    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_pass", 32'(pass_count), 32'd0);
    send(32'h7FFF_FFFF, 32'd1, 3'b101, 32'h8000_0000, 1'b1, 1'b0);
    send(32'h8000_0000, 32'd1, 3'b110, 32'h7FFF_FFFF, 1'b1, 1'b0);
    send(32'd30, 32'd30, 3'b110, 32'd0, 1'b0, 1'b1);
    stop = 1'b1;
    send(32'h7FFF_FFFF, 32'd1, 3'b101, 32'h8000_0000, 1'b0, 1'b0);
    stop = 1'b0;
    tick();
    chk("arith_done", 32'(done), 32'd1);
    chk("arith_pass", 32'(pass_count), 32'd3);
    chk("arith_fail", 32'(fail_count), 32'd1);
    chk("arith_error", 32'(error), 32'd1);
    chk("arith_ff_idx", 32'(ff_idx), 32'd3);

    // First-fail capture and two-edge scoring latency
    pulse_start();
    chk("ff_clear_err", 32'(error), 32'd0);
    send(32'd1, 32'd1, 3'b101, 32'd2, 1'b0, 1'b0);
    chk("lat_not_yet", 32'(pass_count), 32'd0);
    send(32'd5, 32'd3, 3'b001, 32'd1, 1'b0, 1'b0);
    chk("lat_scored", 32'(pass_count), 32'd1);
    send(32'd10, 32'd20, 3'b101, 32'd31, 1'b0, 1'b0);
    send(32'd5, 32'd3, 3'b010, 32'd6, 1'b0, 1'b0);
    send(32'd5, 32'd3, 3'b011, 32'd0, 1'b0, 1'b1);
    pulse_stop();
    tick();
    chk("ff_fail", 32'(fail_count), 32'd2);
    chk("ff_pass", 32'(pass_count), 32'd3);
    chk("ff_idx", 32'(ff_idx), 32'd2);
    chk("ff_exp", ff_exp, 32'd30);
    chk("ff_act", ff_act, 32'd31);
    chk("ff_error", 32'(error), 32'd1);

    // in_valid in DONE is ignored
    send(32'd5, 32'd3, 3'b011, 32'd0, 1'b0, 1'b0);
    tick();
    chk("done_gate_fail", 32'(fail_count), 32'd2);
    chk("done_gate_pass", 32'(pass_count), 32'd3);

    // Overflow ignored for logic ops; start during RUN does not clear
    pulse_start();
    send(32'd5, 32'd3, 3'b011, 32'd7, 1'b1, 1'b0);
    pulse_start();
    chk("run_start_pass", 32'(pass_count), 32'd1);
    chk("run_start_busy", 32'(busy), 32'd1);
    pulse_stop();
    tick();
    chk("ovf_ign_pass", 32'(pass_count), 32'd1);
    chk("ovf_ign_fail", 32'(fail_count), 32'd0);

    // Saturation: 20 passes then one failure
    pulse_start();
    for (int i = 1; i <= 20; i++) begin
      send(32'(i), 32'(i), 3'b011, 32'(i), 1'b0, 1'b0);
    end
    send(32'd1, 32'd1, 3'b011, 32'd0, 1'b0, 1'b0);
    pulse_stop();
    tick();
    chk("sat_pass4", 32'(s_pass), 32'd15);
    chk("sat_pass16", 32'(pass_count), 32'd20);
    chk("sat_fail4", 32'(s_fail), 32'd1);
    chk("sat_idx4", 32'(s_idx), 32'd15);
    chk("sat_idx16", 32'(ff_idx), 32'd20);
    chk("sat_exp4", s_exp, 32'd1);

    // Reset with three vectors in flight
    pulse_start();
    send(32'd5, 32'd3, 3'b001, 32'd1, 1'b0, 1'b0);
    send(32'd5, 32'd3, 3'b010, 32'd0, 1'b0, 1'b0);
    send(32'd5, 32'd3, 3'b011, 32'd7, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pass", 32'(pass_count), 32'd0);
    chk("mid_rst_fail", 32'(fail_count), 32'd0);
    chk("mid_rst_err", 32'(error), 32'd0);
    tick();
    rst = 1'b0;
    // IDLE gating: vectors and stop are ignored
    send(32'd5, 32'd3, 3'b011, 32'd0, 1'b0, 1'b0);
    pulse_stop();
    tick();
    tick();
    chk("idle_pass", 32'(pass_count), 32'd0);
    chk("idle_fail", 32'(fail_count), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_response_checker.md
# alu_response_checker

Self-checking response monitor for the 32-bit ALU: it is the receiving end of the ALU stimulus stream, where the ALU bench only drives vectors and prints results. For each vector (A, B, M, S1, S0) it takes the ALU's outputs (result, add_sub_overflow, iszero) and computes its own expected values. It compares the two, keeps pass/fail counts and captures the first mismatch. It sits beside the ALU in lab benches and on-board self-test, and gives a single sticky error flag.

## Interface
- WIDTH, 32, operand/result width
- CNT_W, 16, width of pass/fail/index counters
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a check session and clears all counters and captures
- stop  in  1  pulse; ends session after pipeline drains
- in_valid  in  1  vector and ALU response valid this cycle
- A, B  in  WIDTH  operands applied to the ALU
- M, S1, S0  in  1 each  ALU op select applied
- result  in  WIDTH  ALU result for that vector
- add_sub_overflow  in  1  ALU overflow output
- iszero  in  1  ALU zero flag
- busy  out  1  session active (RUN or DRAIN)
- done  out  1  session finished; level until next start
- error  out  1  sticky; any mismatch this session
- pass_count, fail_count  out  CNT_W  saturating counts
- first_fail_idx  out  CNT_W  index of first failing vector
- first_fail_expected, first_fail_actual  out  WIDTH  result values of first failing vector

## Operation
- Expected result by {M,S1,S0}: 000 ~A; 001 A&B; 010 A^B; 011 A|B; 100 A-1; 101 A+B; 110 A-B; 111 A+1. All arithmetic modulo 2^WIDTH.
- Expected overflow, signed two's complement: for 101, set when A and B have the same sign and the sum sign differs. For 110, set when A and B signs differ and the difference sign differs from A. Overflow is compared only for 101/110 and ignored for other ops.
- Expected iszero = (expected result == 0), compared for all ops.
- A vector fails if result, iszero or the applicable overflow mismatches.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start -> RUN. Clears counters, error, captures and the vector index; done goes 0.
  - RUN: each cycle with in_valid=1 the vector is accepted and the index increments.
  - RUN + stop -> DRAIN. in_valid in the same cycle as stop is still accepted.
  - DRAIN -> DONE after 1 cycle, once the last accepted vector is scored.
  - start while in RUN/DRAIN is ignored. stop outside RUN is ignored. start and stop together in IDLE: start wins.
- in_valid outside RUN is ignored (not counted, no index increment).
- Counters and the index saturate at 2^CNT_W-1 and do not wrap. A saturated index still tags failures.
- First-fail capture is loaded only on the first failure of the session and holds afterwards.

## Timing
- Stage 1: at edge k with in_valid=1 in RUN, register the inputs and compute the expected values from the registered copy.
- Stage 2: at edge k+1, the compare result updates pass_count/fail_count, error and the captures. Scoring latency is 2 edges from presentation.
- Back-to-back vectors are allowed every cycle, with no backpressure.
- busy = 1 in RUN and DRAIN. done = 1 only in DONE.
- Reset (asynchronous, any time including mid-session): FSM to IDLE; busy, done and error 0; all counters and captures 0; pipeline valid cleared. Vectors in flight are discarded.

## Test plan
- Reset mid-session: assert rst while 3 vectors are in flight -> all outputs 0 immediately, state IDLE, no later count change.
- Logic ops, correct ALU: start, then A=5,B=3 with ops 001/010/011 and results 1/6/7, then A=5 op 000 with result 0xFFFFFFFA, then stop -> pass_count=4, fail_count=0, error=0, done=1 two cycles after stop.
- Arithmetic/overflow: A=0x7FFFFFFF,B=1 op 101, result 0x80000000, ovf=1 -> pass. A=0x80000000,B=1 op 110, result 0x7FFFFFFF, ovf=1 -> pass. A=30,B=30 op 110, result 0, iszero=1, ovf=0 -> pass. Repeat the first vector with ovf=0 -> fail.
- First-fail capture: 5 vectors where index 2 (A=10,B=20 op 101) reports 31 and index 4 also fails -> fail_count=2, first_fail_idx=2, expected=30, actual=31, error=1.
- Overflow ignore and gating: op 011 with ovf=1 and correct result -> pass. in_valid pulses in IDLE/DONE -> counts unchanged. start during RUN -> counters not cleared.
- Saturation (CNT_W=4): 20 passing vectors -> pass_count holds at 15.
